// File: rtl/alu_op_sequencer.sv
// Issue stage for the 4-bit ALU: buffers commands in a FIFO, issues one at a time
// on registered operand lines, captures the ALU result and presents it on valid/ready.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [2:0] in_ctrl,
  input  logic       in_use_acc,
  input  logic       acc_clr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_ctrl,
  input  logic [3:0] alu_res,
  input  logic       alu_car,
  input  logic       alu_of,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_res,
  output logic       out_car,
  output logic       out_of,
  output logic [3:0] acc,
  output logic       busy
);

  typedef struct packed {
    logic       use_acc;
    logic [2:0] ctrl;
    logic [3:0] b;
    logic [3:0] a;
  } cmd_t;

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  state_t        state;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state == IDLE) && !empty && (!out_valid || out_ready);
  assign head     = mem[rd_ptr];
  assign busy     = (state == EXEC) || !empty || out_valid;

  // NOTE: command storage has no reset; an entry is only ever read while count says it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{use_acc: in_use_acc, ctrl: in_ctrl, b: in_b, a: in_a};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: non-blocking updates mean an issuing use_acc command reads acc as it was
  // before this edge, so a same-edge acc_clr cannot affect it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_car   <= 1'b0;
      out_of    <= 1'b0;
      acc       <= '0;
    end else begin
      if (acc_clr)                acc       <= '0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            alu_a    <= head.use_acc ? acc : head.a;
            alu_b    <= head.b;
            alu_ctrl <= head.ctrl;
            state    <= EXEC;
          end
        end
        EXEC: begin
          // A capture overrides the handshake clear; acc_clr overrides the acc update.
          out_res   <= alu_res;
          out_car   <= alu_car;
          out_of    <= alu_of;
          out_valid <= 1'b1;
          acc       <= acc_clr ? 4'd0 : alu_res;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream issue stage for the 4-bit ALU. Buffers operation commands (a, b, ctrl, accumulate flag) in a small FIFO.
- Issues one command at a time on registered ALU operand/control lines, then captures the ALU's combinational result and flags one cycle later.
- Presents the result on a valid/ready output port.
- Keeps an accumulator holding the last result, so a command can use it in place of operand a (chained operations).

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- AW, 2, FIFO pointer width = log2(DEPTH)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  command offered
- in_ready  out  1  FIFO can accept; equals !full
- in_a  in  4  operand a
- in_b  in  4  operand b
- in_ctrl  in  3  ALU op code (000 add … 111 equal-compare)
- in_use_acc  in  1  1 = replace a with accumulator at issue
- acc_clr  in  1  synchronous accumulator clear
- alu_a  out  4  registered operand to ALU
- alu_b  out  4  registered operand to ALU
- alu_ctrl  out  3  registered op to ALU
- alu_res  in  4  ALU result (combinational from alu_a/alu_b/alu_ctrl)
- alu_car  in  1  ALU carry
- alu_of  in  1  ALU overflow
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_res  out  4  captured result
- out_car  out  1  captured carry
- out_of  out  1  captured overflow
- acc  out  4  accumulator value
- busy  out  1  state==EXEC or FIFO non-empty or out_valid

Behaviour:
- **Reset** (async, rst=1): FIFO empty (pointers, count = 0); state IDLE; alu_a, alu_b, alu_ctrl = 0; out_valid, out_res, out_car, out_of = 0; acc = 0; in_ready = 1. Reset asserted mid-operation discards the in-flight command and all queued commands, with no output.
- **Push**: on an edge where in_valid && in_ready, write {in_use_acc, in_ctrl, in_b, in_a} at the write pointer. Pointers wrap modulo DEPTH; count +1.
- **FSM, 2 states**:
  - IDLE: if !empty && (!out_valid || out_ready), then at that edge pop the head and go to EXEC.
    - alu_a ← (use_acc ? acc : a); alu_b ← b; alu_ctrl ← ctrl.
    - Otherwise stay in IDLE; alu_* hold their last values.
  - EXEC: at the next edge capture out_res ← alu_res, out_car ← alu_car, out_of ← alu_of; set out_valid ← 1; acc ← alu_res; go to IDLE.
- **Latency**: command accepted at edge E0 into an empty FIFO with a free output → popped at E1 → out_valid high after E2.
- **Throughput**: at most one command per 2 cycles. Only one command is in flight at a time, so no accumulator hazard: a chained command issues at or after the edge that updates acc.
- **Output handshake**:
  - out_valid clears on an edge with out_valid && out_ready, unless a capture occurs at the same edge, in which case the new result loads and out_valid stays 1.
  - out_res, out_car, out_of are stable while out_valid && !out_ready.
- **Simultaneous push and pop**: both occur at the same edge; count is unchanged. Full is evaluated before the edge, so a push while full is refused even if a pop occurs at that edge.
- **Empty FIFO**: no issue. A push into an empty FIFO cannot issue at the same edge; the earliest issue is the next edge.
- **acc_clr**:
  - acc ← 0 at the edge.
  - Priority over an EXEC capture into acc at the same edge; out_res still captures alu_res.
  - A use_acc command issuing at that edge uses the pre-clear acc value.
- **Width rules**: all data is 4 bits. No arithmetic is done here; car/of come solely from the ALU.

Test Plan:
- **Single add**: reset, push a=0011 b=0101 ctrl=000 use_acc=0, out_ready=1 → out_valid high 2 edges after accept; out_res=1000, out_car=0, out_of=1; acc=1000.
- **Chain**: push a=0010 b=0011 add, then use_acc=1 b=0100 add, back-to-back → results 0101 then 1001 (of=1, car=0); acc=1001; the second alu_a is 0101.
- **Backpressure/full** (DEPTH=4): hold out_ready=0, push continuously → exactly 5 accepted (1 issued + 4 queued), then in_ready=0. out_res stays at the first result. Raising out_ready drains all 5 in push order.
- **Carry path**: push a=1111 b=0001 ctrl=000 → out_res=0000, out_car=1, out_of=0.
- **acc_clr collision**: assert acc_clr on the EXEC edge of a=0110 b=0001 add → out_res=0111, acc=0000. The next use_acc add with b=0011 → out_res=0011.
- **Reset mid-op**: assert rst while in EXEC with 2 commands queued → out_valid=0, in_ready=1, acc=0, alu_a/b/ctrl=0; no result appears after release.
